// File: rtl/lsu_bus_master.sv
// Data-memory bus initiator: one aligned load/store per request, word bus, lane-aligned load return.
// Latency: start to done 3 cycles minimum (1 REQ + 1 RESP); misaligned requests complete after 1 cycle.
// Backpressure: holds the request until bus_gnt, waits for bus_rvalid; core stalls on busy; timeout aborts.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   start/is_store/funct3     core request strobe, direction and RV32I access size
//   addr/store_data           byte address and store operand
//   bus_req/we/addr/be/wrdata bus request channel (held stable until bus_gnt)
//   bus_gnt/rvalid/rddata     bus grant and response channel
//   load_data                 aligned load result, held until the next load completes
//   busy/done/misaligned/bus_err  core status: stall, completion pulse, error pulses
//
// Optional feature macro: LSU_SIGN_EXTEND_EN
//   defined   -> load_data is sign-extended for LB/LH, zero-extended for LBU/LHU
//   undefined -> load_data is zero-filled above the access size
// TIMEOUT_CYCLES must be >= 2 and 2**CNT_W > TIMEOUT_CYCLES.

module lsu_bus_master #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wrdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rddata,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Last active cycle index before the transaction is abandoned.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       size_q;
  logic [1:0]       off_q;

  logic [1:0]  size_c;
  logic        mis_c;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [31:0] shifted;
  logic [31:0] ld_c;

  // Request decode. Reserved size codes (011/110/111) behave as a word access.
  always_comb begin
    size_c = SZ_W;
    case (funct3)
      3'b000, 3'b100: size_c = SZ_B;
      3'b001, 3'b101: size_c = SZ_H;
      default:        size_c = SZ_W;
    endcase
  end

  always_comb begin
    mis_c = 1'b0;
    be_c  = 4'b1111;
    wd_c  = store_data;
    case (size_c)
      SZ_B: begin
        be_c = 4'b0001 << addr[1:0];
        wd_c = {4{store_data[7:0]}};
      end
      SZ_H: begin
        mis_c = addr[0];
        be_c  = 4'b0011 << {addr[1], 1'b0};
        wd_c  = {2{store_data[15:0]}};
      end
      default: begin
        mis_c = (addr[1:0] != 2'b00);
      end
    endcase
    // Loads never drive write data onto the bus.
    if (!is_store) wd_c = 32'h0;
  end

`ifdef LSU_SIGN_EXTEND_EN
  logic sext_q;

  // Signed loads (LB/LH) have funct3[2] clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sext_q <= 1'b0;
    end else if (state == IDLE && start) begin
      sext_q <= ~funct3[2];
    end
  end
`endif

  // Response alignment: bring the addressed lane down to bit 0, then trim or extend.
  always_comb begin
    shifted = bus_rddata >> {off_q, 3'b000};
    ld_c    = shifted;
    case (size_q)
      SZ_B:    ld_c = {24'h0, shifted[7:0]};
      SZ_H:    ld_c = {16'h0, shifted[15:0]};
      default: ld_c = shifted;
    endcase
`ifdef LSU_SIGN_EXTEND_EN
    if (sext_q) begin
      case (size_q)
        SZ_B:    ld_c[31:8]  = {24{shifted[7]}};
        SZ_H:    ld_c[31:16] = {16{shifted[15]}};
        default: ;
      endcase
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      size_q     <= SZ_B;
      off_q      <= 2'b00;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0;
      bus_be     <= 4'h0;
      bus_wrdata <= 32'h0;
      load_data  <= 32'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (mis_c) begin
              // Rejected without touching the bus.
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              state      <= REQ;
              cnt        <= '0;
              size_q     <= size_c;
              off_q      <= addr[1:0];
              bus_req    <= 1'b1;
              bus_we     <= is_store;
              bus_addr   <= {addr[31:2], 2'b00};
              bus_be     <= be_c;
              bus_wrdata <= wd_c;
              busy       <= 1'b1;
            end
          end
        end
        REQ, RESP: begin
          // A response only counts once granted; rvalid alongside gnt in REQ is ignored.
          if (state == RESP && bus_rvalid) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (!bus_we) load_data <= ld_c;
          end else if (cnt == CNT_LAST) begin
            state   <= IDLE;
            busy    <= 1'b0;
            bus_req <= 1'b0;
            done    <= 1'b1;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (state == REQ && bus_gnt) begin
              state   <= RESP;
              bus_req <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
